rr_grant_arbiter: RTL and testbench



---
 rtl/rr_arb_pkg.sv | 38 +++
 rtl/rr_grant_arbiter_dec.sv | 13 +
 rtl/rr_grant_arbiter.sv | 110 +++++++++++
 tb/tb_rr_grant_arbiter.sv | 162 ++++++++++++++++
 4 files changed

// File: rtl/rr_arb_pkg.sv
// Shared types and helpers for the round-robin grant arbiter.
// Build option RR_GRANT_ARBITER_LOCK_EN adds a lock input to the top.
package rr_arb_pkg;

  localparam int N_REQ_DEF    = 4;
  localparam int MAX_HOLD_DEF = 8;
  localparam int N_MAX        = 32;

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } state_t;

  typedef struct packed {
    logic found;
    int   idx;
  } win_t;

  // First asserted req at or after ptr, wrapping modulo n.
  function automatic win_t next_winner(
    input logic [N_MAX-1:0] req,
    input int               ptr,
    input int               n
  );
    win_t w;
    int   j;
    w = '0;
    for (int k = 0; k < N_MAX; k++) begin
      j = (ptr + k) % n;
      if (k < n && !w.found && req[j[4:0]]) begin
        w.found = 1'b1;
        w.idx   = j;
      end
    end
    return w;
  endfunction

endpackage

// File: rtl/rr_grant_arbiter_dec.sv
// Index to one-hot decoder with enable; all-zero when disabled.
module idx_onehot_dec #(
  parameter int N = 4,
  parameter int W = $clog2(N)
) (
  input  logic [W-1:0] idx,
  input  logic         en,
  output logic [N-1:0] onehot
);

  assign onehot = en ? (N'(1) << idx) : '0;

endmodule

// File: rtl/rr_grant_arbiter.sv
// Round-robin arbiter with registered one-hot grant and hold limit.
// Build option RR_GRANT_ARBITER_LOCK_EN adds a lock input.
module rr_grant_arbiter
  import rr_arb_pkg::*;
#(
  parameter int N_REQ    = N_REQ_DEF,
  parameter int MAX_HOLD = MAX_HOLD_DEF,
  localparam int W_IDX   = $clog2(N_REQ)
) (
  input  logic             clk,
  input  logic             rst_n,
`ifdef RR_GRANT_ARBITER_LOCK_EN
  input  logic             lock,
`endif
  input  logic [N_REQ-1:0] req,
  output logic [N_REQ-1:0] gnt,
  output logic [W_IDX-1:0] gnt_idx,
  output logic             gnt_valid
);

  localparam int W_HOLD = (MAX_HOLD > 1) ? $clog2(MAX_HOLD) : 1;
  localparam logic [W_HOLD-1:0] HOLD_LAST = W_HOLD'(MAX_HOLD - 1);
  localparam logic [W_IDX-1:0]  IDX_LAST  = W_IDX'(N_REQ - 1);

  state_t             state_q, state_d;
  logic [W_IDX-1:0]   idx_q, idx_d;
  logic [W_IDX-1:0]   ptr_q, ptr_d;
  logic [W_HOLD-1:0]  hold_q, hold_d;
  logic               lk;
  logic               others;
  logic [W_IDX-1:0]   win_idx;
  win_t               win;

`ifdef RR_GRANT_ARBITER_LOCK_EN
  assign lk = lock;
`else
  assign lk = 1'b0;
`endif

  assign win     = next_winner(N_MAX'(req), int'(ptr_q), N_REQ);
  assign win_idx = W_IDX'(win.idx);
  assign others  = |(req & ~gnt);

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    ptr_d   = ptr_q;
    hold_d  = hold_q;
    unique case (state_q)
      IDLE: begin
        if (win.found) begin
          state_d = GRANT;
          idx_d   = win_idx;
          ptr_d   = (win_idx == IDX_LAST) ? '0 : win_idx + 1'b1;
          hold_d  = '0;
        end
      end
      GRANT: begin
        if (!req[idx_q]) begin
          hold_d = '0;
          if (win.found) begin
            idx_d = win_idx;
            ptr_d = (win_idx == IDX_LAST) ? '0 : win_idx + 1'b1;
          end else begin
            state_d = IDLE;
          end
        end else if (lk) begin
          hold_d = hold_q;
        end else if (hold_q == HOLD_LAST) begin
          // ptr = owner+1, so the owner is searched last
          hold_d = '0;
          if (others) begin
            idx_d = win_idx;
            ptr_d = (win_idx == IDX_LAST) ? '0 : win_idx + 1'b1;
          end
        end else begin
          hold_d = hold_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      idx_q   <= '0;
      ptr_q   <= '0;
      hold_q  <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      ptr_q   <= ptr_d;
      hold_q  <= hold_d;
    end
  end

  assign gnt_valid = (state_q == GRANT);
  assign gnt_idx   = idx_q;

  idx_onehot_dec #(
    .N(N_REQ),
    .W(W_IDX)
  ) u_dec (
    .idx   (idx_q),
    .en    (gnt_valid),
    .onehot(gnt)
  );

endmodule

// File: tb/tb_rr_grant_arbiter.sv
// Directed testbench for rr_grant_arbiter (N_REQ=4, MAX_HOLD=8).
module tb_rr_grant_arbiter;

  logic       clk;
  logic       rst_n;
  logic [3:0] req;
  logic [3:0] gnt;
  logic [1:0] gnt_idx;
  logic       gnt_valid;
`ifdef RR_GRANT_ARBITER_LOCK_EN
  logic       lock;
`endif

  int checks;
  int failures;

  rr_grant_arbiter dut (
    .clk      (clk),
    .rst_n    (rst_n),
`ifdef RR_GRANT_ARBITER_LOCK_EN
    .lock     (lock),
`endif
    .req      (req),
    .gnt      (gnt),
    .gnt_idx  (gnt_idx),
    .gnt_valid(gnt_valid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_own(input string tag, input int k);
    logic [6:0] obs;
    logic [6:0] exp;
    obs = {gnt_valid, gnt_idx, gnt};
    exp = {1'b1, 2'(k), 4'(1 << k)};
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic chk_idle(input string tag);
    logic [4:0] obs;
    obs = {gnt_valid, gnt};
    checks++;
    assert (obs === 5'b0) else begin
      failures++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, 5'b0);
    end
  endtask

  always @(negedge clk) begin
    if (rst_n === 1'b1) begin
      checks++;
      assert ($onehot0(gnt) && (gnt_valid === |gnt)) else begin
        failures++;
        $error("FAIL invariant observed gnt=%b valid=%b expected onehot0",
               gnt, gnt_valid);
      end
    end
  end

  initial begin
    checks   = 0;
    failures = 0;
    rst_n    = 1'b0;
    req      = 4'b1111;
`ifdef RR_GRANT_ARBITER_LOCK_EN
    lock     = 1'b0;
`endif
    step();
    chk_idle("reset_hold0");
    step();
    chk_idle("reset_hold1");
    #2 rst_n = 1'b1;
    step();
    chk_own("first_grant", 0);

    for (int k = 0; k < 4; k++) begin
      req = 4'hF;
      step();
      chk_own("rot_keep", k);
      req = 4'hF & ~4'(1 << k);
      step();
      chk_own("rot_next", (k + 1) % 4);
    end
    req = 4'b0000;
    step();
    chk_idle("rot_idle");

    req = 4'b0011;
    for (int c = 0; c < 24; c++) begin
      step();
      chk_own("preempt", (c < 8) ? 1 : ((c < 16) ? 0 : 1));
    end

    req = 4'b0001;
    for (int c = 0; c < 20; c++) begin
      step();
      chk_own("solo_hold", 0);
    end

    req = 4'b1000;
    step();
    chk_own("wrap_own3", 3);
    req = 4'b1101;
    step();
    chk_own("wrap_keep3", 3);
    req = 4'b0101;
    step();
    chk_own("wrap_to0", 0);
    req = 4'b0100;
    step();
    chk_own("wrap_to2", 2);

    #3 rst_n = 1'b0;
    #1 chk_idle("async_reset");
    step();
    #2 rst_n = 1'b1;
    step();
    chk_own("post_reset_2", 2);
    #3 rst_n = 1'b0;
    req = 4'b1100;
    step();
    #2 rst_n = 1'b1;
    step();
    chk_own("ptr_restart", 2);
    req = 4'b0000;
    step();
    chk_idle("end_idle");

`ifdef RR_GRANT_ARBITER_LOCK_EN
    req = 4'b0010;
    step();
    chk_own("lock_own1", 1);
    req  = 4'b0011;
    lock = 1'b1;
    for (int c = 0; c < 20; c++) begin
      step();
      chk_own("lock_hold", 1);
    end
    lock = 1'b0;
    for (int c = 0; c < 8; c++) begin
      step();
      chk_own("unlock", (c < 7) ? 1 : 0);
    end
    req = 4'b0000;
    step();
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
